// File: rtl/bstream_pkg.sv
// Shared definitions for the bit-stream decoder and the top-level mux wiring.
package bstream_pkg;

    // Default result width; the top-level mux zero-fills above this when narrower.
    localparam int DEFAULT_WIDTH = 8;

    // Decoder control states.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/bstream_decoder.sv
// Converts a serial stochastic 1-bit stream back to a WIDTH-bit binary value by
// counting ones over a window of 2^WIDTH accepted samples.
//
// Handshake: bit_valid qualifies bit_in for one cycle (no backpressure); a
// low bit_valid is a stall and nothing is counted. value_valid is a one-cycle
// strobe with value/saturated held until the next completed window.
module bstream_decoder
    import bstream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             start,
    input  logic             continuous,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             saturated,
    output logic             busy
);

    localparam logic [WIDTH-1:0] SAMPLE_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SAMPLE_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q,       state_d;
    logic [WIDTH-1:0] sample_cnt_q,  sample_cnt_d;
    logic [WIDTH:0]   ones_cnt_q,    ones_cnt_d;
    logic [WIDTH-1:0] value_q,       value_d;
    logic             value_valid_q, value_valid_d;
    logic             saturated_q,   saturated_d;

    // Ones count including the current sample; never wraps since max is 2^WIDTH.
    logic [WIDTH:0]   ones_next;

    // Next-state, counter and result logic; start has priority over completion.
    always_comb begin
        state_d       = state_q;
        sample_cnt_d  = sample_cnt_q;
        ones_cnt_d    = ones_cnt_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        saturated_d   = saturated_q;
        ones_next     = ones_cnt_q + {{WIDTH{1'b0}}, bit_in};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = COUNT;
                    sample_cnt_d = '0;
                    ones_cnt_d   = '0;
                end
            end
            COUNT: begin
                if (start) begin
                    // Restart: this cycle's sample is dropped, no result latched.
                    sample_cnt_d = '0;
                    ones_cnt_d   = '0;
                end else if (bit_valid) begin
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        // All-ones window clips to the largest representable value.
                        value_d       = ones_next[WIDTH] ? {WIDTH{1'b1}} : ones_next[WIDTH-1:0];
                        saturated_d   = ones_next[WIDTH];
                        value_valid_d = 1'b1;
                        sample_cnt_d  = '0;
                        ones_cnt_d    = '0;
                        state_d       = continuous ? COUNT : IDLE;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SAMPLE_ONE;
                        ones_cnt_d   = ones_next;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sample_cnt_q  <= '0;
            ones_cnt_q    <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            saturated_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_cnt_q  <= sample_cnt_d;
            ones_cnt_q    <= ones_cnt_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            saturated_q   <= saturated_d;
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign saturated   = saturated_q;
    assign busy        = (state_q == COUNT);

endmodule

// File: tb/tb_bstream_decoder.sv
// Bench for bstream_decoder: a WIDTH=8 and a WIDTH=3 instance share one
// stimulus bus; each step checks the instance its window length belongs to.
module tb_bstream_decoder;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       start;
    logic       continuous;

    logic [7:0] value8;
    logic       vv8, sat8, busy8;
    logic [2:0] value3;
    logic       vv3, sat3, busy3;

    int n_tests = 0;
    int n_fail  = 0;

    bstream_decoder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .start(start), .continuous(continuous),
        .value(value8), .value_valid(vv8), .saturated(sat8), .busy(busy8)
    );

    bstream_decoder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .start(start), .continuous(continuous),
        .value(value3), .value_valid(vv3), .saturated(sat3), .busy(busy3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output accessors by width
    function automatic logic [31:0] o_value(input int w);
        return (w == 8) ? {24'd0, value8} : {29'd0, value3};
    endfunction
    function automatic logic o_vv(input int w);
        return (w == 8) ? vv8 : vv3;
    endfunction
    function automatic logic o_sat(input int w);
        return (w == 8) ? sat8 : sat3;
    endfunction
    function automatic logic o_busy(input int w);
        return (w == 8) ? busy8 : busy3;
    endfunction

    // One clock edge; outputs are read 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample pattern generator indexed by accepted-sample number.
    function automatic logic pat(input int kind, input int idx);
        case (kind)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (idx % 2 == 0);
            3:       return (idx < 64);
            5:       return (idx % 8 < 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Single-shot window: start, feed 2^w accepted samples, check the result.
    // stall: 0 = none, 1 = valid on every other cycle (low first), 2 = random.
    task automatic run_window(input int w, input int kind, input int stall, input string tag);
        int   n, ones, acc, cyc, pulses, exp_val;
        logic b, v;
        logic [31:0] held;
        n = 1 << w;
        ones = 0; acc = 0; cyc = 0; pulses = 0;
        continuous = 1'b0;
        start = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
        tick();
        start = 1'b0;
        chk({tag, "_busy_at_start"}, 32'(o_busy(w)), 32'd1);
        while (acc < n && cyc < 16 * n + 16) begin
            case (stall)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 1);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            b = pat(kind, acc);
            bit_valid = v;
            bit_in = b;
            if (v) begin
                ones += int'(b);
                acc++;
            end
            if (o_vv(w)) pulses++;
            tick();
            cyc++;
        end
        bit_valid = 1'b0;
        bit_in = 1'b0;
        exp_val = (ones > n - 1) ? n - 1 : ones;
        chk({tag, "_samples_fed"}, 32'(acc), 32'(n));
        chk({tag, "_early_pulse"}, 32'(pulses), 32'd0);
        if (stall == 0) chk({tag, "_cycles"}, 32'(cyc), 32'(n));
        if (stall == 1) chk({tag, "_cycles"}, 32'(cyc), 32'(2 * n));
        chk({tag, "_valid"}, 32'(o_vv(w)), 32'd1);
        chk({tag, "_value"}, o_value(w), 32'(exp_val));
        chk({tag, "_sat"}, 32'(o_sat(w)), 32'(ones == n));
        chk({tag, "_busy_drop"}, 32'(o_busy(w)), 32'd0);
        held = o_value(w);
        tick();
        chk({tag, "_valid_one_cycle"}, 32'(o_vv(w)), 32'd0);
        chk({tag, "_value_held"}, o_value(w), 32'(exp_val));
        if (held !== o_value(w)) chk({tag, "_hold_stable"}, o_value(w), held);
    endtask

    initial begin : main
        int pulses, last, bad_val, bad_gap, exp_pulses, ones, pre;
        logic b;

        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; start = 1'b0; continuous = 1'b0;
        tick();
        tick();
        chk("rst_value8", o_value(8), 32'd0);
        chk("rst_vv8",    32'(vv8),   32'd0);
        chk("rst_sat8",   32'(sat8),  32'd0);
        chk("rst_busy8",  32'(busy8), 32'd0);
        chk("rst_value3", o_value(3), 32'd0);
        chk("rst_busy3",  32'(busy3), 32'd0);
        rst_n = 1'b1;
        tick();

        // Idle ignores samples
        bit_valid = 1'b1; bit_in = 1'b1;
        tick(); tick();
        chk("idle_busy", 32'(busy8), 32'd0);
        chk("idle_vv",   32'(vv8),   32'd0);
        bit_valid = 1'b0; bit_in = 1'b0;

        // WIDTH=8 windows
        run_window(8, 0, 0, "w8_zeros");
        run_window(8, 1, 0, "w8_ones");
        run_window(8, 2, 0, "w8_alt");
        run_window(8, 3, 0, "w8_64ones");
        run_window(8, 4, 2, "w8_rand_stall");

        // WIDTH=3 windows
        run_window(3, 1, 1, "w3_toggle_valid");
        for (int i = 0; i < 4; i++) run_window(3, 4, 2, "w3_rand");

        // Continuous mode with 3-ones/5-zeros pattern, drop continuous at sample 34
        pulses = 0; last = -1; bad_val = 0; bad_gap = 0; exp_pulses = 0;
        for (int k = 0; k < 48; k++)
            if ((k + 1) % 8 == 0 && (k / 8) * 8 <= 34) exp_pulses++;
        continuous = 1'b1; start = 1'b1; bit_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 48; k++) begin
            if (k == 34) continuous = 1'b0;
            bit_valid = 1'b1;
            bit_in = pat(5, k);
            tick();
            if (vv3) begin
                pulses++;
                if (value3 != 3'd3 || sat3 != 1'b0) bad_val++;
                if (last >= 0 && k - last != 8) bad_gap++;
                last = k;
            end
        end
        bit_valid = 1'b0; bit_in = 1'b0;
        chk("cont_pulses",    32'(pulses),  32'(exp_pulses));
        chk("cont_values",    32'(bad_val), 32'd0);
        chk("cont_gap",       32'(bad_gap), 32'd0);
        chk("cont_last_at",   32'(last),    32'd39);
        chk("cont_busy_end",  32'(busy3),   32'd0);

        // Restart at sample 5: those 5 ones are discarded
        pulses = 0; ones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            if (vv3) pulses++;
            tick();
        end
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        if (vv3) pulses++;
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy3), 32'd1);
        for (int k = 0; k < 8; k++) begin
            b = pat(4, k);
            bit_valid = 1'b1; bit_in = b;
            ones += int'(b);
            if (vv3) pulses++;
            tick();
        end
        bit_valid = 1'b0;
        chk("restart_no_pulse", 32'(pulses), 32'd0);
        chk("restart_valid",    32'(vv3),    32'd1);
        chk("restart_value",    o_value(3),  32'((ones > 7) ? 7 : ones));
        tick();

        // Start coinciding with the last sample: no result latched
        pre = int'(value3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bit_valid = 1'b1; bit_in = 1'b0;
            tick();
        end
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
        tick();
        start = 1'b0;
        chk("start_last_no_pulse", 32'(vv3),     32'd0);
        chk("start_last_value",    o_value(3),   32'(pre));
        for (int k = 0; k < 8; k++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        chk("start_last_valid", 32'(vv3),   32'd1);
        chk("start_last_full",  o_value(3), 32'd7);
        chk("start_last_sat",   32'(sat3),  32'd1);
        tick();

        // Reset at sample 5
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("rst_mid_value", o_value(3), 32'd0);
        chk("rst_mid_sat",   32'(sat3),  32'd0);
        chk("rst_mid_vv",    32'(vv3),   32'd0);
        chk("rst_mid_busy",  32'(busy3), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
            if (vv3 || busy3) pulses++;
        end
        bit_valid = 1'b0;
        chk("rst_mid_stays_idle", 32'(pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
